product_sequencer: RTL and testbench

- Upstream feeder for the product register file in the 2x2 matrix multiplier.
- Accepts two 2x2 matrices of unsigned ELEM_W-bit elements and computes the 8 partial products A[i][k]*B[k][j] with one sequential shift-add multiplier.
- Writes each product into register-file slot {i,j,k} using the file's product/specifier/update-strobe interface.
- The downstream adder sums slots {i,j,0} and {i,j,1} to form C[i][j].

---
 rtl/matmul_pkg.sv | 28 ++
 rtl/shift_add_mult.sv | 51 +++++
 rtl/product_sequencer.sv | 142 ++++++++++++++
 tb/tb_product_sequencer.sv | 211 +++++++++++++++++++++
 4 files changed

// File: rtl/matmul_pkg.sv
// Shared types and constants for the 2x2 matrix multiplier product path.
package matmul_pkg;

  localparam int unsigned ELEM_W             = 4;
  localparam int unsigned PROD_W             = 2 * ELEM_W;
  localparam int unsigned MAT_W              = 4 * ELEM_W;
  localparam int unsigned NUM_PRODUCTS       = 8;
  localparam int unsigned SLOT_W             = 3;
  localparam int unsigned CYCLES_PER_PRODUCT = ELEM_W + 2;
  localparam int unsigned STEP_W             = $clog2(ELEM_W);

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_LOAD  = 3'd1,
    ST_MULT  = 3'd2,
    ST_WRITE = 3'd3,
    ST_DONE  = 3'd4
  } state_e;

  // Element at (row,col) of a packed 2x2 matrix, row-major, element 00 in the LSBs.
  function automatic logic [ELEM_W-1:0] elem(input logic [MAT_W-1:0] mat,
                                             input logic row, input logic col);
    logic [MAT_W-1:0] shifted;
    shifted = mat >> (ELEM_W * {row, col});
    return shifted[ELEM_W-1:0];
  endfunction

endpackage

// File: rtl/shift_add_mult.sv
// Sequential unsigned shift-add multiplier; one partial-product step per step pulse.
module shift_add_mult
  import matmul_pkg::*;
(
  input  logic              clk,
  input  logic              reset,
  input  logic              load,
  input  logic              step,
  input  logic [ELEM_W-1:0] multiplicand,
  input  logic [ELEM_W-1:0] multiplier,
  output logic [PROD_W-1:0] product_c
);

  logic [PROD_W-1:0] mcand_q, mcand_d;
  logic [ELEM_W-1:0] mplr_q, mplr_d;
  logic [PROD_W-1:0] acc_q, acc_d;

  // product_c is the accumulator value after this cycle's step, so the
  // sequencer can register the finished product on the final step edge.
  assign product_c = acc_d;

  always_comb begin
    mcand_d = mcand_q;
    mplr_d  = mplr_q;
    acc_d   = acc_q;
    if (load) begin
      mcand_d = PROD_W'(multiplicand);
      mplr_d  = multiplier;
      acc_d   = '0;
    end else if (step) begin
      if (mplr_q[0]) begin
        acc_d = acc_q + mcand_q;
      end
      mplr_d  = mplr_q >> 1;
      mcand_d = mcand_q << 1;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      mcand_q <= '0;
      mplr_q  <= '0;
      acc_q   <= '0;
    end else begin
      mcand_q <= mcand_d;
      mplr_q  <= mplr_d;
      acc_q   <= acc_d;
    end
  end

endmodule

// File: rtl/product_sequencer.sv
// Computes the 8 partial products A[i][k]*B[k][j] and writes them to register-file slots {i,j,k}.
module product_sequencer
  import matmul_pkg::*;
(
  input  logic              clk,
  input  logic              reset,
  input  logic              start,
  input  logic [MAT_W-1:0]  mat_a,
  input  logic [MAT_W-1:0]  mat_b,
  output logic              busy,
  output logic              done,
  output logic [PROD_W-1:0] product_out,
  output logic [SLOT_W-1:0] reg_specifier,
  output logic              update_file_reg
);

  // LOAD and WRITE take one cycle each; the remainder of a product slot is MULT.
  localparam int unsigned MULT_STEPS = CYCLES_PER_PRODUCT - 2;

  state_e            state_q, state_d;
  logic [SLOT_W-1:0] p_q, p_d;
  logic [STEP_W-1:0] cnt_q, cnt_d;
  logic [MAT_W-1:0]  mat_a_q, mat_a_d;
  logic [MAT_W-1:0]  mat_b_q, mat_b_d;
  logic              busy_q, busy_d;
  logic              done_q, done_d;
  logic [PROD_W-1:0] prod_q, prod_d;
  logic [SLOT_W-1:0] spec_q, spec_d;
  logic              upd_q, upd_d;

  logic              mult_load_c;
  logic              mult_step_c;
  logic [ELEM_W-1:0] mcand_c;
  logic [ELEM_W-1:0] mplr_c;
  logic [PROD_W-1:0] mult_prod_c;

  // p = {i,j,k}: multiplicand A[i][k], multiplier B[k][j].
  assign mcand_c = elem(mat_a_q, p_q[2], p_q[0]);
  assign mplr_c  = elem(mat_b_q, p_q[0], p_q[1]);

  shift_add_mult u_mult (
    .clk          (clk),
    .reset        (reset),
    .load         (mult_load_c),
    .step         (mult_step_c),
    .multiplicand (mcand_c),
    .multiplier   (mplr_c),
    .product_c    (mult_prod_c)
  );

  always_comb begin
    state_d     = state_q;
    p_d         = p_q;
    cnt_d       = cnt_q;
    mat_a_d     = mat_a_q;
    mat_b_d     = mat_b_q;
    prod_d      = prod_q;
    spec_d      = spec_q;
    upd_d       = 1'b0;
    done_d      = 1'b0;
    mult_load_c = 1'b0;
    mult_step_c = 1'b0;

    case (state_q)
      ST_IDLE: begin
        if (start) begin
          mat_a_d = mat_a;
          mat_b_d = mat_b;
          p_d     = '0;
          state_d = ST_LOAD;
        end
      end
      ST_LOAD: begin
        mult_load_c = 1'b1;
        cnt_d       = '0;
        state_d     = ST_MULT;
      end
      ST_MULT: begin
        mult_step_c = 1'b1;
        cnt_d       = cnt_q + STEP_W'(1);
        // Outputs are registered, so the write strobe is set up on the last step edge.
        if (cnt_q == STEP_W'(MULT_STEPS - 1)) begin
          state_d = ST_WRITE;
          upd_d   = 1'b1;
          prod_d  = mult_prod_c;
          spec_d  = p_q;
        end
      end
      ST_WRITE: begin
        if (p_q == SLOT_W'(NUM_PRODUCTS - 1)) begin
          p_d     = '0;
          done_d  = 1'b1;
          state_d = ST_DONE;
        end else begin
          p_d     = p_q + SLOT_W'(1);
          state_d = ST_LOAD;
        end
      end
      ST_DONE: begin
        state_d = ST_IDLE;
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase

    busy_d = (state_d != ST_IDLE);
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= ST_IDLE;
      p_q     <= '0;
      cnt_q   <= '0;
      mat_a_q <= '0;
      mat_b_q <= '0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
      prod_q  <= '0;
      spec_q  <= '0;
      upd_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      p_q     <= p_d;
      cnt_q   <= cnt_d;
      mat_a_q <= mat_a_d;
      mat_b_q <= mat_b_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
      prod_q  <= prod_d;
      spec_q  <= spec_d;
      upd_q   <= upd_d;
    end
  end

  assign busy            = busy_q;
  assign done            = done_q;
  assign product_out     = prod_q;
  assign reg_specifier   = spec_q;
  assign update_file_reg = upd_q;

endmodule

// File: tb/tb_product_sequencer.sv
// Scoreboard bench for product_sequencer: expected slot/product pairs queued at start, popped per strobe.
module tb_product_sequencer;

  logic        clk = 1'b0;
  logic        reset;
  logic        start;
  logic [15:0] mat_a;
  logic [15:0] mat_b;
  logic        busy;
  logic        done;
  logic [7:0]  product_out;
  logic [2:0]  reg_specifier;
  logic        update_file_reg;

  product_sequencer dut (
    .clk             (clk),
    .reset           (reset),
    .start           (start),
    .mat_a           (mat_a),
    .mat_b           (mat_b),
    .busy            (busy),
    .done            (done),
    .product_out     (product_out),
    .reg_specifier   (reg_specifier),
    .update_file_reg (update_file_reg)
  );

  always #5 clk = ~clk;

  typedef struct {
    int         slot;
    logic [7:0] prod;
  } exp_t;

  exp_t       sb[$];
  int         n_cmp = 0;
  int         n_err = 0;
  logic [7:0] hold_prod = 8'd0;
  logic [2:0] hold_spec = 3'd0;

  // Reference product for slot p = {i,j,k}: A[i][k] * B[k][j].
  function automatic logic [7:0] ref_prod(input logic [15:0] a, input logic [15:0] b, input int p);
    int i, j, k, ea, eb;
    i  = (p >> 2) & 1;
    j  = (p >> 1) & 1;
    k  = p & 1;
    ea = int'((a >> (4 * (2 * i + k))) & 16'hF);
    eb = int'((b >> (4 * (2 * k + j))) & 16'hF);
    return 8'(ea * eb);
  endfunction

  task automatic test_reset();
    reset = 1'b1;
    start = 1'b0;
    mat_a = 16'h0;
    mat_b = 16'h0;
    repeat (2) @(posedge clk);
    #1 reset = 1'b0;
    for (int c = 0; c < 10; c++) begin
      @(negedge clk);
      n_cmp++;
      if ({busy, done, update_file_reg, product_out, reg_specifier} !== 14'd0) begin
        n_err++;
        $display("FAIL reset_idle cycle=%0d got busy=%b done=%b upd=%b prod=%h spec=%0d exp all 0",
                 c, busy, done, update_file_reg, product_out, reg_specifier);
      end
    end
    hold_prod = 8'd0;
    hold_spec = 3'd0;
  endtask

  // One launched operation; restart_at re-asserts start in that cycle, reset_at is the first cycle after a mid-run reset.
  task automatic run_case(input string tag, input logic [15:0] a, input logic [15:0] b,
                          input int restart_at, input int reset_at);
    exp_t e;
    int   strobes;
    int   exp_strobes;
    logic exp_busy;
    logic exp_done;
    logic in_reset;
    strobes     = 0;
    exp_strobes = 0;
    sb.delete();
    for (int p = 0; p < 8; p++) begin
      e.slot = p;
      e.prod = ref_prod(a, b, p);
      sb.push_back(e);
      if (reset_at == 0 || (6 + 6 * p) < reset_at) exp_strobes++;
    end

    @(negedge clk);
    mat_a = a;
    mat_b = b;
    start = 1'b1;
    @(posedge clk);
    #1 start = 1'b0;

    for (int n = 1; n <= 56; n++) begin
      @(negedge clk);
      in_reset = (reset_at != 0) && (n >= reset_at);
      if (in_reset) begin
        hold_prod = 8'd0;
        hold_spec = 3'd0;
      end
      exp_busy = (n <= 49) && !in_reset;
      exp_done = (n == 49) && (reset_at == 0);

      n_cmp++;
      if (busy !== exp_busy) begin
        n_err++;
        $display("FAIL %s busy cycle=%0d got %b exp %b", tag, n, busy, exp_busy);
      end
      n_cmp++;
      if (done !== exp_done) begin
        n_err++;
        $display("FAIL %s done cycle=%0d got %b exp %b", tag, n, done, exp_done);
      end

      if (update_file_reg === 1'b1) begin
        n_cmp++;
        if (in_reset || sb.size() == 0) begin
          n_err++;
          $display("FAIL %s unexpected_strobe cycle=%0d got upd=1 exp 0", tag, n);
        end else begin
          e = sb.pop_front();
          if (reg_specifier !== 3'(e.slot) || product_out !== e.prod || n != 6 + 6 * e.slot) begin
            n_err++;
            $display("FAIL %s strobe cycle=%0d got slot=%0d prod=%0d exp slot=%0d prod=%0d cycle=%0d",
                     tag, n, reg_specifier, product_out, e.slot, e.prod, 6 + 6 * e.slot);
          end
          hold_prod = e.prod;
          hold_spec = 3'(e.slot);
          strobes++;
        end
      end else if (update_file_reg !== 1'b0) begin
        n_cmp++;
        n_err++;
        $display("FAIL %s upd_unknown cycle=%0d got %b exp 0/1", tag, n, update_file_reg);
      end else if (strobes > 0 || in_reset) begin
        n_cmp++;
        if (product_out !== hold_prod || reg_specifier !== hold_spec) begin
          n_err++;
          $display("FAIL %s hold cycle=%0d got prod=%0d spec=%0d exp prod=%0d spec=%0d",
                   tag, n, product_out, reg_specifier, hold_prod, hold_spec);
        end
      end

      // Stimulus for the next edge.
      if (n == 2) begin
        mat_a = 16'($urandom);
        mat_b = 16'($urandom);
      end
      start = (restart_at != 0) && (n == restart_at - 1);
      reset = (reset_at != 0) && (n == reset_at - 1);
    end

    n_cmp++;
    if (strobes != exp_strobes) begin
      n_err++;
      $display("FAIL %s strobe_count got %0d exp %0d", tag, strobes, exp_strobes);
    end
    sb.delete();
    start = 1'b0;
    reset = 1'b0;
  endtask

  task automatic test_basic();
    run_case("basic", 16'h4321, 16'h8765, 0, 0);
  endtask

  task automatic test_max_operands();
    run_case("max", 16'hFFFF, 16'hFFFF, 0, 0);
  endtask

  task automatic test_zero_identity();
    run_case("zero", 16'h0000, 16'h8765, 0, 0);
    run_case("identity", 16'h1001, 16'h8765, 0, 0);
  endtask

  task automatic test_back_to_back();
    run_case("busy_restart", 16'h9A5C, 16'h37E2, 20, 0);
  endtask

  task automatic test_reset_mid();
    run_case("reset_mid", 16'h4321, 16'h8765, 0, 25);
    run_case("after_reset", 16'hB7D3, 16'h2F6E, 0, 0);
  endtask

  task automatic test_random();
    for (int r = 0; r < 3; r++) begin
      run_case("random", 16'($urandom), 16'($urandom), 0, 0);
    end
  endtask

  initial begin
    reset = 1'b1;
    start = 1'b0;
    mat_a = 16'h0;
    mat_b = 16'h0;
    test_reset();
    test_basic();
    test_max_operands();
    test_zero_identity();
    test_back_to_back();
    test_reset_mid();
    test_random();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
